// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions and exception codes.
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LSB     = 8;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 8;
    localparam int CAUSE_TI_BIT  = 30;
    localparam int CAUSE_BD_BIT  = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a programmable prescaler and a sticky timer-interrupt flag.
module cp0_timer #(
    parameter int COUNT_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] din_i,
    input  logic        countWe_i,
    input  logic        compareWe_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    localparam logic [3:0] PRESC_LAST = 4'(COUNT_DIV - 1);

    logic [3:0]  presc_q, presc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;
    logic        armed_q, armed_d;
    logic        tick;
    logic        hit;

    // armed_q keeps the Count==Compare==0 state right after reset from firing;
    // it arms as soon as Count moves or either register is written.
    always_comb begin
        tick      = (presc_q == PRESC_LAST);
        hit       = armed_q && (count_q == compare_q);
        presc_d   = tick ? 4'd0 : presc_q + 4'd1;
        count_d   = tick ? count_q + 32'd1 : count_q;
        armed_d   = armed_q | tick;
        compare_d = compare_q;
        ti_d      = ti_q | hit;
        if (countWe_i) begin
            count_d = din_i;
            presc_d = 4'd0;
            armed_d = 1'b1;
        end
        if (compareWe_i) begin
            compare_d = din_i;
            ti_d      = 1'b0;
            armed_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q   <= 4'd0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
            armed_q   <= armed_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_ext.sv
// CP0 status/cause/EPC block with interrupt request generation and an embedded timer.
module cp0_ext
    import cp0_pkg::*;
#(
    parameter int          NUM_HWINT = 5,
    parameter logic [31:0] PRID      = 32'h21074113,
    parameter int          COUNT_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [29:0]          pc,
    input  logic                 bd,
    input  logic [31:0]          din,
    input  logic [4:0]           sel,
    input  logic                 cp0WR,
    input  logic                 exc_req,
    input  logic [4:0]           exc_code,
    input  logic                 eret,
    input  logic [NUM_HWINT-1:0] HWint,
    output logic                 IntReq,
    output logic [29:0]          epc,
    output logic [31:0]          dout
);

    logic [7:0]           im_q, im_d;
    logic                 ie_q, ie_d;
    logic                 exl_q, exl_d;
    logic [1:0]           sw_q, sw_d;
    logic [NUM_HWINT-1:0] hw_q;
    logic                 bd_q, bd_d;
    logic [4:0]           code_q, code_d;
    logic [29:0]          epc_q, epc_d;

    logic [31:0] count, compare;
    logic        ti;
    logic [4:0]  hwPad;
    logic [7:0]  ip;
    logic [31:0] sr, cause;
    logic        wrSr, wrCause, wrEpc;

    assign wrSr    = cp0WR && (sel == REG_SR);
    assign wrCause = cp0WR && (sel == REG_CAUSE);
    assign wrEpc   = cp0WR && (sel == REG_EPC);

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk_i       (clk),
        .rst_i       (rst),
        .din_i       (din),
        .countWe_i   (cp0WR && (sel == REG_COUNT)),
        .compareWe_i (cp0WR && (sel == REG_COMPARE)),
        .count_o     (count),
        .compare_o   (compare),
        .ti_o        (ti)
    );

    // Later assignments win: mtc0 write, then eret, then exception entry.
    always_comb begin
        im_d   = im_q;
        ie_d   = ie_q;
        exl_d  = exl_q;
        sw_d   = sw_q;
        bd_d   = bd_q;
        code_d = code_q;
        epc_d  = epc_q;
        if (wrSr) begin
            im_d  = din[SR_IM_LSB +: 8];
            exl_d = din[SR_EXL_BIT];
            ie_d  = din[SR_IE_BIT];
        end
        if (wrCause) sw_d = din[CAUSE_IP_LSB +: 2];
        if (wrEpc) epc_d = din[31:2];
        if (eret) exl_d = 1'b0;
        if (exc_req) begin
            code_d = exc_code;
            exl_d  = 1'b1;
            epc_d  = epc_q;
            if (!exl_q) begin
                epc_d = bd ? pc - 30'd1 : pc;
                bd_d  = bd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_q   <= 8'd0;
            ie_q   <= 1'b0;
            exl_q  <= 1'b0;
            sw_q   <= 2'd0;
            hw_q   <= '0;
            bd_q   <= 1'b0;
            code_q <= 5'd0;
            epc_q  <= 30'd0;
        end else begin
            im_q   <= im_d;
            ie_q   <= ie_d;
            exl_q  <= exl_d;
            sw_q   <= sw_d;
            hw_q   <= HWint;
            bd_q   <= bd_d;
            code_q <= code_d;
            epc_q  <= epc_d;
        end
    end

    // Unimplemented hardware lines read as 0 in IP[6:2].
    always_comb begin
        hwPad = 5'd0;
        hwPad[NUM_HWINT-1:0] = hw_q;
        ip = {ti, hwPad, sw_q};

        sr = 32'd0;
        sr[SR_IE_BIT]        = ie_q;
        sr[SR_EXL_BIT]       = exl_q;
        sr[SR_IM_LSB +: 8]   = im_q;

        cause = 32'd0;
        cause[CAUSE_EXC_LSB +: 5] = code_q;
        cause[CAUSE_IP_LSB +: 8]  = ip;
        cause[CAUSE_TI_BIT]       = ti;
        cause[CAUSE_BD_BIT]       = bd_q;

        case (sel)
            REG_COUNT:   dout = count;
            REG_COMPARE: dout = compare;
            REG_SR:      dout = sr;
            REG_CAUSE:   dout = cause;
            REG_EPC:     dout = {epc_q, 2'b00};
            REG_PRID:    dout = PRID;
            default:     dout = 32'd0;
        endcase
    end

    assign IntReq = (|(ip & im_q)) & ie_q & ~exl_q;
    assign epc    = epc_q;

endmodule

// File: tb/tb_cp0_ext.sv
// Self-checking bench for cp0_ext: directed vector table, timer/reset sequences and a randomized model run.
module tb_cp0_ext;

    logic        clk = 1'b0;
    logic        rst, bd, cp0WR, exc_req, eret;
    logic [29:0] pc;
    logic [31:0] din;
    logic [4:0]  sel, exc_code, HWint;
    logic        IntReq;
    logic [29:0] epc;
    logic [31:0] dout;

    logic        rst4, we4, irq4;
    logic [4:0]  sel4;
    logic [31:0] din4, dout4;
    logic [29:0] epc4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cp0_ext u1 (
        .clk(clk), .rst(rst), .pc(pc), .bd(bd), .din(din), .sel(sel), .cp0WR(cp0WR),
        .exc_req(exc_req), .exc_code(exc_code), .eret(eret), .HWint(HWint),
        .IntReq(IntReq), .epc(epc), .dout(dout)
    );

    cp0_ext #(.COUNT_DIV(4)) u4 (
        .clk(clk), .rst(rst4), .pc(30'd0), .bd(1'b0), .din(din4), .sel(sel4), .cp0WR(we4),
        .exc_req(1'b0), .exc_code(5'd0), .eret(1'b0), .HWint(5'd0),
        .IntReq(irq4), .epc(epc4), .dout(dout4)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  sel;
        logic [31:0] din;
        logic        exc;
        logic [4:0]  code;
        logic [29:0] pc;
        logic        bd;
        logic        eret;
        logic [4:0]  hw;
        logic [4:0]  rdSel;
        logic [31:0] expDout;
        logic        expIrq;
        logic [29:0] expEpc;
    } vec_t;

    vec_t vecs[21];

    // Reference model state, updated from the architectural rules once per clock.
    bit [31:0] mCount, mCompare;
    bit        mTi, mFresh, mIe, mExl, mBd;
    bit [7:0]  mIm;
    bit [1:0]  mSw;
    bit [4:0]  mHw, mCode;
    bit [29:0] mEpc;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; cp0WR = 1'b0; exc_req = 1'b0; eret = 1'b0;
        bd = 1'b0; pc = 30'd0; din = 32'd0; exc_code = 5'd0;
    endtask

    task automatic applyStimulus(input vec_t v);
        rst = v.rst; cp0WR = v.we; sel = v.sel; din = v.din; exc_req = v.exc;
        exc_code = v.code; pc = v.pc; bd = v.bd; eret = v.eret; HWint = v.hw;
    endtask

    task automatic readCheck(input string name, input logic [4:0] s, input logic [31:0] exp);
        sel = s;
        #1;
        checkOutput(name, dout, exp);
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic modelReset();
        mCount = 0; mCompare = 0; mTi = 0; mFresh = 1; mIe = 0; mExl = 0; mBd = 0;
        mIm = 0; mSw = 0; mHw = 0; mCode = 0; mEpc = 0;
    endtask

    function automatic logic [31:0] modelRead(input logic [4:0] s);
        logic [7:0] ipv;
        ipv = {mTi, mHw, mSw};
        case (s)
            5'd9:    return mCount;
            5'd11:   return mCompare;
            5'd12:   return {16'd0, mIm, 6'd0, mExl, mIe};
            5'd13:   return {mBd, mTi, 14'd0, ipv, 1'b0, mCode, 2'b00};
            5'd14:   return {mEpc, 2'b00};
            5'd15:   return 32'h21074113;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic modelIrq();
        return (|({mTi, mHw, mSw} & mIm)) && mIe && !mExl;
    endfunction

    task automatic modelStep();
        bit hitNow, oldExl;
        if (rst) begin
            modelReset();
        end else begin
            oldExl = mExl;
            hitNow = !mFresh && (mCount == mCompare);
            if (cp0WR && sel == 5'd11) begin
                mCompare = din;
                mTi = 0;
            end else if (hitNow) begin
                mTi = 1;
            end
            if (cp0WR && sel == 5'd9) mCount = din;
            else mCount = mCount + 32'd1;
            mFresh = 0;
            mHw = HWint;
            if (cp0WR && sel == 5'd13) mSw = din[9:8];
            if (cp0WR && sel == 5'd12) begin
                mIm = din[15:8]; mIe = din[0]; mExl = din[1];
            end
            if (cp0WR && sel == 5'd14 && !exc_req) mEpc = din[31:2];
            if (eret) mExl = 0;
            if (exc_req) begin
                if (!oldExl) begin
                    mEpc = bd ? pc - 30'd1 : pc;
                    mBd = bd;
                end
                mExl = 1;
                mCode = exc_code;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //           rst   we    sel    din           exc   code   pc          bd    eret  hw     rd     expDout       irq   expEpc
        vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  30'h0,      1'b0, 1'b0, 5'h0,  5'd12, 32'h0,        1'b0, 30'h0};
        vecs[1]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  30'h0,      1'b0, 1'b0, 5'h0,  5'd13, 32'h0,        1'b0, 30'h0};
        vecs[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  30'h0,      1'b0, 1'b0, 5'h0,  5'd15, 32'h21074113, 1'b0, 30'h0};
        vecs[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  30'h0,      1'b0, 1'b0, 5'h0,  5'd7,  32'h0,        1'b0, 30'h0};
        vecs[4]  = '{1'b0, 1'b1, 5'd12, 32'h401,      1'b0, 5'd0,  30'h0,      1'b0, 1'b0, 5'h0,  5'd12, 32'h401,      1'b0, 30'h0};
        vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  30'h0,      1'b0, 1'b0, 5'h1,  5'd13, 32'h400,      1'b1, 30'h0};
        vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  30'h100,    1'b0, 1'b0, 5'h1,  5'd12, 32'h403,      1'b0, 30'h100};
        vecs[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  30'h0,      1'b0, 1'b1, 5'h0,  5'd12, 32'h401,      1'b0, 30'h100};
        vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  30'h200,    1'b1, 1'b0, 5'h0,  5'd13, 32'h80000010, 1'b0, 30'h1FF};
        vecs[9]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 30'h300,    1'b0, 1'b0, 5'h0,  5'd13, 32'h80000030, 1'b0, 30'h1FF};
        vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  30'h0,      1'b0, 1'b0, 5'h0,  5'd14, 32'h7FC,      1'b0, 30'h1FF};
        vecs[11] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  30'h0,      1'b0, 1'b1, 5'h0,  5'd12, 32'h401,      1'b0, 30'h1FF};
        vecs[12] = '{1'b0, 1'b1, 5'd13, 32'h100,      1'b0, 5'd0,  30'h0,      1'b0, 1'b0, 5'h0,  5'd13, 32'h80000130, 1'b0, 30'h1FF};
        vecs[13] = '{1'b0, 1'b1, 5'd12, 32'h501,      1'b0, 5'd0,  30'h0,      1'b0, 1'b0, 5'h0,  5'd12, 32'h501,      1'b1, 30'h1FF};
        vecs[14] = '{1'b0, 1'b1, 5'd12, 32'h0,        1'b1, 5'd5,  30'h40,     1'b0, 1'b0, 5'h0,  5'd13, 32'h114,      1'b0, 30'h40};
        vecs[15] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  30'h50,     1'b0, 1'b1, 5'h0,  5'd12, 32'h2,        1'b0, 30'h40};
        vecs[16] = '{1'b0, 1'b1, 5'd14, 32'h12345678, 1'b0, 5'd0,  30'h0,      1'b0, 1'b0, 5'h0,  5'd14, 32'h12345678, 1'b0, 30'h048D159E};
        vecs[17] = '{1'b0, 1'b1, 5'd15, 32'hFFFFFFFF, 1'b0, 5'd0,  30'h0,      1'b0, 1'b0, 5'h0,  5'd15, 32'h21074113, 1'b0, 30'h048D159E};
        vecs[18] = '{1'b0, 1'b1, 5'd13, 32'hFFFFFFFF, 1'b0, 5'd0,  30'h0,      1'b0, 1'b0, 5'h0,  5'd13, 32'h320,      1'b0, 30'h048D159E};
        vecs[19] = '{1'b0, 1'b1, 5'd13, 32'h0,        1'b0, 5'd0,  30'h0,      1'b0, 1'b0, 5'h0,  5'd13, 32'h20,       1'b0, 30'h048D159E};
        vecs[20] = '{1'b1, 1'b1, 5'd12, 32'h403,      1'b1, 5'd4,  30'h77,     1'b1, 1'b0, 5'h0,  5'd12, 32'h0,        1'b0, 30'h0};

        idle();
        sel = 5'd0; HWint = 5'd0;
        rst4 = 1'b1; we4 = 1'b0; sel4 = 5'd0; din4 = 32'd0;

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            afterEdge();
            sel = vecs[i].rdSel;
            #1;
            checkOutput($sformatf("vec%0d dout", i), dout, vecs[i].expDout);
            checkOutput($sformatf("vec%0d IntReq", i), {31'd0, IntReq}, {31'd0, vecs[i].expIrq});
            checkOutput($sformatf("vec%0d epc", i), {2'b00, epc}, {2'b00, vecs[i].expEpc});
        end

        // Timer at COUNT_DIV=1: Compare=5 then Count=0; TI appears on the edge after Count reaches 5.
        @(negedge clk); idle(); cp0WR = 1'b1; sel = 5'd11; din = 32'd5;
        afterEdge();
        @(negedge clk); cp0WR = 1'b1; sel = 5'd9; din = 32'd0;
        afterEdge();
        readCheck("count loaded", 5'd9, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        readCheck("count at compare", 5'd9, 32'd5);
        readCheck("TI not yet", 5'd13, 32'd0);
        @(posedge clk);
        #1;
        readCheck("TI set", 5'd13, 32'h40008000);
        @(negedge clk); cp0WR = 1'b1; sel = 5'd12; din = 32'h8001;
        afterEdge();
        readCheck("SR timer enable", 5'd12, 32'h8001);
        checkOutput("timer IntReq", {31'd0, IntReq}, 32'd1);
        @(negedge clk); cp0WR = 1'b1; sel = 5'd11; din = 32'h1000;
        afterEdge();
        readCheck("TI cleared", 5'd13, 32'd0);
        checkOutput("timer IntReq off", {31'd0, IntReq}, 32'd0);

        // EPC wraps modulo 2^30 for a delay-slot fault at pc 0.
        @(negedge clk); exc_req = 1'b1; exc_code = 5'd4; pc = 30'd0; bd = 1'b1;
        afterEdge();
        checkOutput("epc wrap", {2'b00, epc}, 32'h3FFFFFFF);
        readCheck("SR after exc", 5'd12, 32'h8003);
        @(negedge clk); cp0WR = 1'b1; sel = 5'd9; din = 32'h1234;
        afterEdge();
        readCheck("count 1234", 5'd9, 32'h1234);

        // Reset while EXL=1 and Count=0x1234, with competing write and exception.
        @(negedge clk); rst = 1'b1; cp0WR = 1'b1; sel = 5'd12; din = 32'hFFFF; exc_req = 1'b1;
        afterEdge();
        readCheck("rst SR", 5'd12, 32'd0);
        readCheck("rst Cause", 5'd13, 32'd0);
        readCheck("rst Count", 5'd9, 32'd0);
        readCheck("rst Compare", 5'd11, 32'd0);
        readCheck("rst EPC", 5'd14, 32'd0);
        checkOutput("rst epc", {2'b00, epc}, 32'd0);
        checkOutput("rst IntReq", {31'd0, IntReq}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        readCheck("no TI at Compare=0", 5'd13, 32'd0);
        readCheck("count after rst", 5'd9, 32'd2);

        // COUNT_DIV=4: the Count write clears the prescaler mid-count, wrap after four cycles.
        @(negedge clk); rst4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); we4 = 1'b1; sel4 = 5'd9; din4 = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        we4 = 1'b0;
        checkOutput("div4 loaded", dout4, 32'hFFFFFFFF);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("div4 cycle%0d", k), dout4, (k < 4) ? 32'hFFFFFFFF : 32'd0);
        end

        // Randomized run against the reference model.
        @(negedge clk); idle(); rst = 1'b1;
        @(posedge clk);
        modelReset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 99) == 0);
            cp0WR = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 7))
                0:       sel = 5'd9;
                1:       sel = 5'd11;
                2:       sel = 5'd12;
                3:       sel = 5'd13;
                4:       sel = 5'd14;
                5:       sel = 5'd15;
                default: sel = 5'($urandom_range(0, 31));
            endcase
            din = $urandom;
            if (sel == 5'd11) din = mCount + 32'($urandom_range(1, 6));
            if (sel == 5'd9 && $urandom_range(0, 1) == 1) din = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
            exc_req  = ($urandom_range(0, 9) == 0);
            exc_code = 5'($urandom);
            pc       = 30'($urandom);
            bd       = 1'($urandom);
            eret     = ($urandom_range(0, 7) == 0);
            HWint    = 5'($urandom);
            #1;
            checkOutput("rnd dout", dout, modelRead(sel));
            checkOutput("rnd IntReq", {31'd0, IntReq}, {31'd0, modelIrq()});
            checkOutput("rnd epc", {2'b00, epc}, {2'b00, mEpc});
            @(posedge clk);
            modelStep();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
